hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller that produces the stall code sampled by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC unit. It detects load-use hazards between Decode and Execute, sequences multi-cycle branch flushes after a taken branch resolves in EX, and freezes the pipeline while a data-memory access awaits acknowledge. It sits beside the decode stage. It is the sole driver of the `stall` bus that the pipeline registers consume.

## Interface
Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles `STALL_BRANCH` is issued per taken branch (1..7; covers fetch latency).
- CNT_WIDTH, 32, width of performance counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- rs1_rd_en_id  input  1  ID instruction reads rs1.
- rs2_rd_en_id  input  1  ID instruction reads rs2.
- rs1_addr_id  input  `REG_ADDR_WIDTH  ID rs1 address.
- rs2_addr_id  input  `REG_ADDR_WIDTH  ID rs2 address.
- mem_read_ex  input  1  EX instruction is a load.
- rd_addr_ex  input  `REG_ADDR_WIDTH  EX destination register.
- branch_taken_ex  input  1  EX resolved a taken branch or jump.
- dmem_req_mem  input  1  MEM stage has an outstanding data-memory request.
- dmem_ack_mem  input  1  data memory completes the request this cycle.
- stall  output  `STALL_WIDTH  stall code to all pipeline registers.
- redirect  output  1  one-cycle pulse: PC unit loads the branch target now.
- load_stall_cnt  output  CNT_WIDTH  load-use bubble cycles.
- branch_flush_cnt  output  CNT_WIDTH  branch flush cycles.
- mem_wait_cnt  output  CNT_WIDTH  memory wait cycles.

## Operation
- Stall codes: `STALL_NONE`, `STALL_LOAD`, `STALL_BRANCH`, `STALL_MEM`.
  - `STALL_LOAD` and `STALL_BRANCH` zero ID/EX.
  - `STALL_LOAD` also holds PC and IF/ID.
  - `STALL_BRANCH` also zeroes IF/ID.
  - `STALL_MEM` holds every pipeline register and the PC.
- Load-use hazard:
  - Condition: mem_read_ex, rd_addr_ex != 0, and (rs1_rd_en_id and rs1_addr_id == rd_addr_ex, or the same for rs2).
  - Action: one bubble. The following cycle has EX = bubble, so the hazard clears naturally.
- Memory wait: dmem_req_mem and not dmem_ack_mem.
- FSM states: RUN, FLUSH, MEM_WAIT.
- RUN, in priority order:
  1. Memory wait → stall = `STALL_MEM`; go to MEM_WAIT. If branch_taken_ex, set pend_br.
  2. Else if branch_taken_ex → stall = `STALL_BRANCH`, redirect = 1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1.
  3. Else if load-use → `STALL_LOAD`.
  4. Else → `STALL_NONE`.
- FLUSH:
  - stall = `STALL_BRANCH`, redirect = 0; cnt decrements each cycle.
  - At cnt == 1, return to RUN.
  - Load-use and new branches are ignored (the instructions are wrong-path).
  - A memory wait overrides with `STALL_MEM` and freezes cnt.
- MEM_WAIT:
  - stall = `STALL_MEM` until dmem_ack_mem; branch_taken_ex ORs into pend_br.
  - Ack cycle with pend_br: stall = `STALL_BRANCH`, redirect = 1, clear pend_br, then FLUSH or RUN as in RUN.
  - Ack cycle without pend_br: evaluate load-use as in RUN and go to RUN.
- Branch beats load-use in the same cycle. The load-use instruction is on the wrong path.

## Timing
- stall and redirect are Mealy outputs: combinational from state and current inputs, with zero latency, sampled by consumers at the same posedge.
- Only state, cnt, pend_br and the counters are registered.
- Reset values: state = RUN, cnt = 0, pend_br = 0, all counters = 0. While rst is high, stall = `STALL_NONE` and redirect = 0.
- Reset mid-flush or mid-wait abandons the sequence at the next edge.
- redirect is exactly one cycle per taken branch, including a branch held across a memory wait.
- Branch penalty: FLUSH_CYCLES cycles plus any memory wait cycles.

## Configuration
- STALL_PERF_EN defined:
  - Each counter increments by 1 on every cycle its stall code is output.
  - Counters saturate at all-ones and clear on rst.
- STALL_PERF_EN undefined: counter registers are not built; counter ports are tied to 0.

## Structure
- `STALL_NONE`, `STALL_LOAD`, `STALL_BRANCH`, `STALL_MEM` and `STALL_WIDTH` live in defines.sv with the other shared constants.
- The FSM state enum (RUN, FLUSH, MEM_WAIT) lives in the shared package stall_pkg.
- One sub-module: sat_counter (CNT_WIDTH, inc, rst), instantiated three times under STALL_PERF_EN.

## Test plan
- Load into x5 in EX, ID reads rs2 = x5 → `STALL_LOAD` for exactly 1 cycle, then `STALL_NONE`; load_stall_cnt = 1.
- Load with rd = x0, ID reads x0 → `STALL_NONE` throughout.
- FLUSH_CYCLES = 3, branch_taken_ex pulse → `STALL_BRANCH` for 3 cycles, redirect high only in the first; branch_flush_cnt = 3.
- dmem_req high, ack after 4 cycles, branch_taken_ex held throughout → `STALL_MEM` ×4, then `STALL_BRANCH` with a single redirect.
- Branch and load-use in the same cycle → `STALL_BRANCH`, no `STALL_LOAD`.
- rst asserted mid-flush (FLUSH_CYCLES = 3, after cycle 1) → next cycle `STALL_NONE`, state RUN, counters 0.

Source files
------------

// File: rtl/stall_pkg.sv
// Shared types for the hazard/stall controller: FSM state enum and register-hit helper.
`include "defines.sv"

package stall_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Wide enough for FLUSH_CYCLES up to 7.
  localparam int FLUSH_CNT_WIDTH = 3;

  function automatic logic reg_hit(
    input logic                       rd_en,
    input logic [`REG_ADDR_WIDTH-1:0] rs_addr,
    input logic [`REG_ADDR_WIDTH-1:0] rd_addr
  );
    return rd_en && (rs_addr == rd_addr);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute/memory hazard inputs and the stall/redirect outputs of the controller.
`include "defines.sv"

interface hazard_stall_ctrl_if;
  logic                       rs1_rd_en_id;
  logic                       rs2_rd_en_id;
  logic [`REG_ADDR_WIDTH-1:0] rs1_addr_id;
  logic [`REG_ADDR_WIDTH-1:0] rs2_addr_id;
  logic                       mem_read_ex;
  logic [`REG_ADDR_WIDTH-1:0] rd_addr_ex;
  logic                       branch_taken_ex;
  logic                       dmem_req_mem;
  logic                       dmem_ack_mem;
  logic [`STALL_WIDTH-1:0]    stall;
  logic                       redirect;

  modport master (
    output rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
    output mem_read_ex, rd_addr_ex, branch_taken_ex,
    output dmem_req_mem, dmem_ack_mem,
    input  stall, redirect
  );

  modport slave (
    input  rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
    input  mem_read_ex, rd_addr_ex, branch_taken_ex,
    input  dmem_req_mem, dmem_ack_mem,
    output stall, redirect
  );
endinterface

// File: rtl/defines.sv
// Shared pipeline constants: register address width and the stall code bus.
`ifndef HAZARD_DEFINES_SV
`define HAZARD_DEFINES_SV

`define REG_ADDR_WIDTH 5
`define STALL_WIDTH    2

`define STALL_NONE     2'd0
`define STALL_LOAD     2'd1
`define STALL_BRANCH   2'd2
`define STALL_MEM      2'd3

`endif

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush sequencing, memory-wait freeze.
// Performance counters are built only when STALL_PERF_EN is defined.
`include "defines.sv"

module hazard_stall_ctrl
  import stall_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus,
  output logic [CNT_WIDTH-1:0] load_stall_cnt,
  output logic [CNT_WIDTH-1:0] branch_flush_cnt,
  output logic [CNT_WIDTH-1:0] mem_wait_cnt
);

  localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_RELOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                     state;
  state_t                     state_n;
  logic [FLUSH_CNT_WIDTH-1:0] cnt;
  logic [FLUSH_CNT_WIDTH-1:0] cnt_n;
  logic                       pend_br;
  logic                       pend_br_n;
  logic                       load_use;
  logic                       mem_wait;
  logic [`STALL_WIDTH-1:0]    stall_c;
  logic                       redirect_c;

  assign load_use = bus.mem_read_ex && (bus.rd_addr_ex != '0) &&
                    (reg_hit(bus.rs1_rd_en_id, bus.rs1_addr_id, bus.rd_addr_ex) ||
                     reg_hit(bus.rs2_rd_en_id, bus.rs2_addr_id, bus.rd_addr_ex));

  assign mem_wait = bus.dmem_req_mem && !bus.dmem_ack_mem;

  always_comb begin
    stall_c    = `STALL_NONE;
    redirect_c = 1'b0;
    state_n    = state;
    cnt_n      = cnt;
    pend_br_n  = pend_br;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            stall_c = `STALL_MEM;
            state_n = MEM_WAIT;
            if (bus.branch_taken_ex) begin
              pend_br_n = 1'b1;
            end
          end else if (bus.branch_taken_ex) begin
            stall_c    = `STALL_BRANCH;
            redirect_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              cnt_n   = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            stall_c = `STALL_LOAD;
          end
        end

        // Instructions behind the branch are wrong-path: hazards and branches are ignored.
        FLUSH: begin
          if (mem_wait) begin
            stall_c = `STALL_MEM;
          end else begin
            stall_c = `STALL_BRANCH;
            cnt_n   = cnt - FLUSH_CNT_WIDTH'(1);
            if (cnt == FLUSH_CNT_WIDTH'(1)) begin
              state_n = RUN;
            end
          end
        end

        MEM_WAIT: begin
          if (!bus.dmem_ack_mem) begin
            stall_c   = `STALL_MEM;
            pend_br_n = pend_br | bus.branch_taken_ex;
          end else if (pend_br || bus.branch_taken_ex) begin
            stall_c    = `STALL_BRANCH;
            redirect_c = 1'b1;
            pend_br_n  = 1'b0;
            state_n    = RUN;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              cnt_n   = FLUSH_RELOAD;
            end
          end else begin
            state_n = RUN;
            if (load_use) begin
              stall_c = `STALL_LOAD;
            end
          end
        end

        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      pend_br <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_br <= pend_br_n;
    end
  end

  assign bus.stall    = stall_c;
  assign bus.redirect = redirect_c;

`ifdef STALL_PERF_EN
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_load_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_c == `STALL_LOAD),
    .count (load_stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_c == `STALL_BRANCH),
    .count (branch_flush_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_c == `STALL_MEM),
    .count (mem_wait_cnt)
  );
`else
  assign load_stall_cnt   = '0;
  assign branch_flush_cnt = '0;
  assign mem_wait_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized run against a reference model.
module tb_hazard_stall_ctrl;

  localparam int FLUSH = 3;
  localparam int CW    = 32;

  localparam logic [1:0] S_NONE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_BRANCH = 2'd2;
  localparam logic [1:0] S_MEM    = 2'd3;

`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mem_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .FLUSH_CYCLES (FLUSH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .load_stall_cnt   (load_cnt),
    .branch_flush_cnt (branch_cnt),
    .mem_wait_cnt     (mem_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the edge; return at the falling edge for sampling.
  task automatic applyStimulus(
    input logic       r,
    input logic       r1en,
    input logic       r2en,
    input logic [4:0] r1,
    input logic [4:0] r2,
    input logic       mr,
    input logic [4:0] rd,
    input logic       br,
    input logic       req,
    input logic       ack
  );
    @(posedge clk);
    #1;
    rst                 = r;
    bus.rs1_rd_en_id    = r1en;
    bus.rs2_rd_en_id    = r2en;
    bus.rs1_addr_id     = r1;
    bus.rs2_addr_id     = r2;
    bus.mem_read_ex     = mr;
    bus.rd_addr_ex      = rd;
    bus.branch_taken_ex = br;
    bus.dmem_req_mem    = req;
    bus.dmem_ack_mem    = ack;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== S_NONE) begin
      n_fail++;
      $display("[TB] FAIL reset_stall: got %0d expected %0d", bus.stall, S_NONE);
    end
    n_checks++;
    if (bus.redirect !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_redirect: got %0d expected 0", bus.redirect);
    end
    idle(1'b0);
    n_checks++;
    if (bus.stall !== S_NONE) begin
      n_fail++;
      $display("[TB] FAIL post_reset_stall: got %0d expected %0d", bus.stall, S_NONE);
    end
    n_checks++;
    if ((load_cnt !== '0) || (branch_cnt !== '0) || (mem_cnt !== '0)) begin
      n_fail++;
      $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", load_cnt, branch_cnt, mem_cnt);
    end
  endtask

  task automatic test_load_use();
    idle(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_LOAD || bus.redirect !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs2: got %0d/%0d expected %0d/0", bus.stall, bus.redirect, S_LOAD);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_NONE) begin
      n_fail++;
      $display("[TB] FAIL load_use_cleared: got %0d expected %0d", bus.stall, S_NONE);
    end
    n_checks++;
    if (load_cnt !== CW'(PERF ? 1 : 0)) begin
      n_fail++;
      $display("[TB] FAIL load_stall_cnt: got %0d expected %0d", load_cnt, PERF ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_LOAD) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs1: got %0d expected %0d", bus.stall, S_LOAD);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_NONE) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs1_disabled: got %0d expected %0d", bus.stall, S_NONE);
    end
  endtask

  task automatic test_load_x0();
    idle(1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.stall !== S_NONE) begin
        n_fail++;
        $display("[TB] FAIL load_x0 cycle %0d: got %0d expected %0d", i, bus.stall, S_NONE);
      end
    end
  endtask

  task automatic test_branch_flush();
    logic [1:0] es;
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      // Wrong-path load-use and a second branch inside the flush must be ignored.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd4, 5'd0, (i == 1), 5'd4, (i == 0) || (i == 2), 1'b0, 1'b0);
      es = (i < 3) ? S_BRANCH : S_NONE;
      n_checks++;
      if (bus.stall !== es || bus.redirect !== (i == 0)) begin
        n_fail++;
        $display("[TB] FAIL branch_flush cycle %0d: got %0d/%0d expected %0d/%0d", i, bus.stall, bus.redirect, es, (i == 0));
      end
    end
    n_checks++;
    if (branch_cnt !== CW'(PERF ? 3 : 0)) begin
      n_fail++;
      $display("[TB] FAIL branch_flush_cnt: got %0d expected %0d", branch_cnt, PERF ? 3 : 0);
    end
  endtask

  task automatic test_mem_wait_branch();
    logic [1:0] es;
    logic       er;
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, (i <= 4), (i <= 4), (i == 4));
      es = (i < 4) ? S_MEM : ((i < 7) ? S_BRANCH : S_NONE);
      er = (i == 4);
      n_checks++;
      if (bus.stall !== es || bus.redirect !== er) begin
        n_fail++;
        $display("[TB] FAIL mem_wait_branch cycle %0d: got %0d/%0d expected %0d/%0d", i, bus.stall, bus.redirect, es, er);
      end
    end
    n_checks++;
    if (mem_cnt !== CW'(PERF ? 4 : 0) || branch_cnt !== CW'(PERF ? 3 : 0)) begin
      n_fail++;
      $display("[TB] FAIL mem_wait_counters: got %0d/%0d expected %0d/%0d", mem_cnt, branch_cnt, PERF ? 4 : 0, PERF ? 3 : 0);
    end
  endtask

  task automatic test_branch_vs_load();
    logic [1:0] es;
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_BRANCH || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL branch_beats_load: got %0d/%0d expected %0d/1", bus.stall, bus.redirect, S_BRANCH);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      es = (i < 2) ? S_BRANCH : S_NONE;
      n_checks++;
      if (bus.stall !== es || bus.redirect !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL branch_vs_load tail %0d: got %0d/%0d expected %0d/0", i, bus.stall, bus.redirect, es);
      end
    end
    n_checks++;
    if (load_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL branch_vs_load_cnt: got %0d expected 0", load_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    idle(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.stall !== S_BRANCH || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midflush_start: got %0d/%0d expected %0d/1", bus.stall, bus.redirect, S_BRANCH);
    end
    idle(1'b1);
    n_checks++;
    if (bus.stall !== S_NONE || bus.redirect !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midflush_in_reset: got %0d/%0d expected %0d/0", bus.stall, bus.redirect, S_NONE);
    end
    idle(1'b0);
    n_checks++;
    if (bus.stall !== S_NONE) begin
      n_fail++;
      $display("[TB] FAIL midflush_abandoned: got %0d expected %0d", bus.stall, S_NONE);
    end
    n_checks++;
    if ((load_cnt !== '0) || (branch_cnt !== '0) || (mem_cnt !== '0)) begin
      n_fail++;
      $display("[TB] FAIL midflush_counters: got %0d/%0d/%0d expected 0/0/0", load_cnt, branch_cnt, mem_cnt);
    end
  endtask

  // Model tracks branch cycles still owed, an open memory wait and a branch parked behind it.
  task automatic test_random();
    int         flush_left = 0;
    bit         waiting    = 1'b0;
    bit         pend       = 1'b0;
    int         m_load     = 0;
    int         m_br       = 0;
    int         m_mem      = 0;
    logic       r, r1en, r2en, mr, br, req, ack, lu, mw, er;
    logic [4:0] r1, r2, rd;
    logic [1:0] es;
    idle(1'b1);
    for (int cyc = 0; cyc < 800; cyc++) begin
      r    = ($urandom_range(0, 63) == 0);
      r1en = 1'($urandom_range(0, 1));
      r2en = 1'($urandom_range(0, 1));
      r1   = 5'($urandom_range(0, 3));
      r2   = 5'($urandom_range(0, 3));
      mr   = ($urandom_range(0, 2) == 0);
      rd   = 5'($urandom_range(0, 3));
      br   = ($urandom_range(0, 9) == 0);
      req  = ($urandom_range(0, 4) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      applyStimulus(r, r1en, r2en, r1, r2, mr, rd, br, req, ack);

      lu = mr && (rd != 5'd0) && ((r1en && (r1 == rd)) || (r2en && (r2 == rd)));
      mw = req && !ack;
      es = S_NONE;
      er = 1'b0;
      if (r) begin
        flush_left = 0;
        waiting    = 1'b0;
        pend       = 1'b0;
      end else if (waiting) begin
        if (!ack) begin
          es   = S_MEM;
          pend = pend | br;
        end else begin
          waiting = 1'b0;
          if (pend || br) begin
            es         = S_BRANCH;
            er         = 1'b1;
            pend       = 1'b0;
            flush_left = FLUSH - 1;
          end else begin
            es = lu ? S_LOAD : S_NONE;
          end
        end
      end else if (flush_left > 0) begin
        if (mw) begin
          es = S_MEM;
        end else begin
          es = S_BRANCH;
          flush_left--;
        end
      end else if (mw) begin
        es      = S_MEM;
        waiting = 1'b1;
        pend    = br;
      end else if (br) begin
        es         = S_BRANCH;
        er         = 1'b1;
        flush_left = FLUSH - 1;
      end else begin
        es = lu ? S_LOAD : S_NONE;
      end

      n_checks++;
      if (bus.stall !== es) begin
        n_fail++;
        $display("[TB] FAIL random_stall cycle %0d: got %0d expected %0d", cyc, bus.stall, es);
      end
      n_checks++;
      if (bus.redirect !== er) begin
        n_fail++;
        $display("[TB] FAIL random_redirect cycle %0d: got %0d expected %0d", cyc, bus.redirect, er);
      end
      n_checks++;
      if (load_cnt !== CW'(PERF ? m_load : 0) || branch_cnt !== CW'(PERF ? m_br : 0) ||
          mem_cnt !== CW'(PERF ? m_mem : 0)) begin
        n_fail++;
        $display("[TB] FAIL random_counters cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", cyc,
                 load_cnt, branch_cnt, mem_cnt, PERF ? m_load : 0, PERF ? m_br : 0, PERF ? m_mem : 0);
      end

      if (r) begin
        m_load = 0;
        m_br   = 0;
        m_mem  = 0;
      end else begin
        if (es == S_LOAD)   m_load++;
        if (es == S_BRANCH) m_br++;
        if (es == S_MEM)    m_mem++;
      end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.rs1_rd_en_id    = 1'b0;
    bus.rs2_rd_en_id    = 1'b0;
    bus.rs1_addr_id     = '0;
    bus.rs2_addr_id     = '0;
    bus.mem_read_ex     = 1'b0;
    bus.rd_addr_ex      = '0;
    bus.branch_taken_ex = 1'b0;
    bus.dmem_req_mem    = 1'b0;
    bus.dmem_ack_mem    = 1'b0;

    test_reset();
    test_load_use();
    test_load_x0();
    test_branch_flush();
    test_mem_wait_branch();
    test_branch_vs_load();
    test_reset_mid_flush();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
